// File: rtl/tlb_cache_pkg.sv
// Shared types for the TLB responder: FSM states and the cache entry layout.
// Entry field widths are the widths the cache is built for.
package tlb_cache_pkg;

  localparam int unsigned TLB_VPN_W = 27;
  localparam int unsigned TLB_PPN_W = 44;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WALK_REQ,
    S_WALK_WAIT,
    S_RESP
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [TLB_VPN_W-1:0] vpn;
    logic [TLB_PPN_W-1:0] ppn;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_cache_if.sv
// Translation request/response bundle between tlb_arbiter and tlb_cache.
interface tlb_if #(
  parameter int unsigned VPN_W = tlb_cache_pkg::TLB_VPN_W,
  parameter int unsigned PPN_W = tlb_cache_pkg::TLB_PPN_W
);
  logic             valid;
  logic [VPN_W-1:0] vpn;
  logic             ack;
  logic [PPN_W-1:0] ppn;

  modport master (output valid, output vpn, input ack, input ppn);
  modport slave  (input valid, input vpn, output ack, output ppn);
endinterface

// File: rtl/tlb_cache_cam.sv
// Combinational fully-associative match plus lowest-free-slot search.
module tlb_cam
  import tlb_cache_pkg::*;
#(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0]   valid_vec,
  input  logic [TLB_VPN_W-1:0] entry_vpn [ENTRIES],
  input  logic [TLB_VPN_W-1:0] vpn,
  output logic                 hit,
  output logic [IDX_W-1:0]     hit_idx,
  output logic [IDX_W-1:0]     free_idx,
  output logic                 any_free
);

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!hit && valid_vec[i] && (entry_vpn[i] == vpn)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Scan downward so the last assignment leaves the lowest invalid index.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int unsigned i = ENTRIES; i > 0; i--) begin
      if (!valid_vec[i-1]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i - 1);
      end
    end
  end

endmodule

// File: rtl/tlb_cache.sv
// Responder end of tlb_if: fully-associative translation cache that walks the
// page table on a miss, installs the result and acknowledges one request at a time.
module tlb_cache
  import tlb_cache_pkg::*;
#(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned VPN_W   = TLB_VPN_W,
  parameter int unsigned PPN_W   = TLB_PPN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  tlb_if.slave             tlb_req,
  input  logic             flush,
  output logic             ptw_req_valid,
  output logic [VPN_W-1:0] ptw_req_vpn,
  input  logic             ptw_req_ready,
  input  logic             ptw_resp_valid,
  input  logic [PPN_W-1:0] ptw_resp_ppn
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0 ||
      VPN_W != TLB_VPN_W || PPN_W != TLB_PPN_W) begin : g_bad_cfg
    $error("tlb_cache: ENTRIES must be a power of two >= 2 and widths must match tlb_entry_t");
  end

  state_t               state;
  tlb_entry_t           entries [ENTRIES];
  logic [VPN_W-1:0]     vpn_r;
  logic [PPN_W-1:0]     ppn_r;
  logic                 ack_r;
  logic                 flush_pend;
  logic [IDX_W-1:0]     rr_ptr;

  logic [ENTRIES-1:0]   valid_vec;
  logic [VPN_W-1:0]     entry_vpn [ENTRIES];
  logic                 hit;
  logic [IDX_W-1:0]     hit_idx;
  logic [IDX_W-1:0]     free_idx;
  logic                 any_free;
  logic [IDX_W-1:0]     install_idx;
  logic                 do_install;

  always_comb begin
    valid_vec = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      valid_vec[i] = entries[i].valid;
      entry_vpn[i] = entries[i].vpn;
    end
  end

  tlb_cam #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_cam (
    .valid_vec (valid_vec),
    .entry_vpn (entry_vpn),
    .vpn       (tlb_req.vpn),
    .hit       (hit),
    .hit_idx   (hit_idx),
    .free_idx  (free_idx),
    .any_free  (any_free)
  );

  // A flush landing on the response edge also suppresses the install.
  always_comb begin
    install_idx = any_free ? free_idx : rr_ptr;
    do_install  = (state == S_WALK_WAIT) && ptw_resp_valid && !flush_pend && !flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        entries[i] <= '0;
      end
      rr_ptr <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        entries[i].valid <= 1'b0;
      end
      rr_ptr <= '0;
    end else if (do_install) begin
      entries[install_idx] <= '{valid: 1'b1, vpn: vpn_r, ppn: ptw_resp_ppn};
      if (!any_free) begin
        rr_ptr <= rr_ptr + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      vpn_r         <= '0;
      ppn_r         <= '0;
      ack_r         <= 1'b0;
      ptw_req_valid <= 1'b0;
      ptw_req_vpn   <= '0;
      flush_pend    <= 1'b0;
    end else begin
      ack_r <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (tlb_req.valid) begin
            vpn_r <= tlb_req.vpn;
            if (hit && !flush) begin
              ppn_r <= entries[hit_idx].ppn;
              ack_r <= 1'b1;
              state <= S_RESP;
            end else begin
              ptw_req_valid <= 1'b1;
              ptw_req_vpn   <= tlb_req.vpn;
              state         <= S_WALK_REQ;
            end
          end
        end
        S_WALK_REQ: begin
          if (flush) begin
            flush_pend <= 1'b1;
          end
          if (ptw_req_ready) begin
            ptw_req_valid <= 1'b0;
            state         <= S_WALK_WAIT;
          end
        end
        S_WALK_WAIT: begin
          if (ptw_resp_valid) begin
            ppn_r      <= ptw_resp_ppn;
            ack_r      <= 1'b1;
            flush_pend <= 1'b0;
            state      <= S_RESP;
          end else if (flush) begin
            flush_pend <= 1'b1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign tlb_req.ack = ack_r;
  assign tlb_req.ppn = ppn_r;

endmodule

// File: tb/tb_tlb_cache.sv
// Directed bench for tlb_cache: vector table of single translations plus
// hand-written sequences for ignored responses, back-to-back hits and reset mid-walk.
module tb_tlb_cache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        ptw_req_valid;
  logic [26:0] ptw_req_vpn;
  logic        ptw_req_ready = 1'b0;
  logic        ptw_resp_valid = 1'b0;
  logic [43:0] ptw_resp_ppn = '0;

  int checks = 0;
  int errors = 0;

  tlb_if #(.VPN_W(27), .PPN_W(44)) bus ();

  tlb_cache #(.ENTRIES(8), .VPN_W(27), .PPN_W(44)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tlb_req        (bus),
    .flush          (flush),
    .ptw_req_valid  (ptw_req_valid),
    .ptw_req_vpn    (ptw_req_vpn),
    .ptw_req_ready  (ptw_req_ready),
    .ptw_resp_valid (ptw_resp_valid),
    .ptw_resp_ppn   (ptw_resp_ppn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [26:0] vpn;
    logic [43:0] resp_ppn;
    bit          walk;
    logic [43:0] exp_ppn;
    int          flush_at;   // -2 none, -1 with valid, k = during cycle k
  } vec_t;

  vec_t vecs [24];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", name, got, exp);
    end
  endtask

  // One translation with a walker that is ready at once and answers two cycles later.
  task automatic run_vec(input string tag, input vec_t v);
    int          req_cycles;
    int          acks;
    int          ack_cyc;
    int          cnt;
    logic [43:0] got_ppn;
    req_cycles = 0;
    acks       = 0;
    ack_cyc    = -1;
    cnt        = -1;
    got_ppn    = '0;
    @(negedge clk);
    bus.vpn   = v.vpn;
    bus.valid = 1'b1;
    flush     = (v.flush_at == -1);
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      flush          = (v.flush_at == cyc);
      ptw_resp_valid = 1'b0;
      ptw_req_ready  = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          ptw_resp_valid = 1'b1;
          ptw_resp_ppn   = v.resp_ppn;
        end
      end
      if (ptw_req_valid) begin
        req_cycles++;
        check({tag, "_req_vpn"}, 64'(ptw_req_vpn), 64'(v.vpn));
        ptw_req_ready = 1'b1;
        cnt = 2;
      end
      if (bus.ack) begin
        acks++;
        if (acks == 1) begin
          ack_cyc = cyc;
          got_ppn = bus.ppn;
        end
        bus.valid = 1'b0;
      end
      if (ack_cyc >= 0 && cyc >= ack_cyc + 2) break;
    end
    flush          = 1'b0;
    bus.valid      = 1'b0;
    ptw_resp_valid = 1'b0;
    ptw_req_ready  = 1'b0;
    check({tag, "_acks"}, 64'(acks), 64'd1);
    check({tag, "_ppn"}, 64'(got_ppn), 64'(v.exp_ppn));
    check({tag, "_walks"}, 64'(req_cycles), v.walk ? 64'd1 : 64'd0);
    check({tag, "_latency"}, 64'(ack_cyc), v.walk ? 64'd3 : 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bus.valid = 1'b0;
    bus.vpn   = '0;

    vecs[0]  = '{27'h123, 44'hABC,  1'b1, 44'hABC,  -2}; // cold miss
    vecs[1]  = '{27'h123, 44'h0,    1'b0, 44'hABC,  -2}; // hit after fill
    vecs[2]  = '{27'h123, 44'hABD,  1'b1, 44'hABD,  -1}; // flush with valid
    vecs[3]  = '{27'h123, 44'h0,    1'b0, 44'hABD,  -2};
    vecs[4]  = '{27'h200, 44'h2222, 1'b1, 44'h2222,  1}; // flush in WALK_WAIT
    vecs[5]  = '{27'h200, 44'h2223, 1'b1, 44'h2223, -2};
    vecs[6]  = '{27'h123, 44'hABE,  1'b1, 44'hABE,  -2};
    vecs[7]  = '{27'h0,   44'h1000, 1'b1, 44'h1000, -1}; // empty cache, vpn 0 -> idx 0
    for (int k = 1; k < 8; k++) begin
      vecs[7+k] = '{27'(k), 44'(32'h1000 + k), 1'b1, 44'(32'h1000 + k), -2};
    end
    vecs[15] = '{27'h8,   44'h1008, 1'b1, 44'h1008, -2}; // evict idx0, rr=1
    vecs[16] = '{27'h0,   44'h2000, 1'b1, 44'h2000, -2}; // evict idx1, rr=2
    vecs[17] = '{27'h1,   44'h2001, 1'b1, 44'h2001, -2}; // evict idx2, rr=3
    vecs[18] = '{27'h3,   44'h0,    1'b0, 44'h1003, -2};
    vecs[19] = '{27'h8,   44'h0,    1'b0, 44'h1008, -2};
    vecs[20] = '{27'h0,   44'h0,    1'b0, 44'h2000, -2};
    vecs[21] = '{27'h2,   44'h2002, 1'b1, 44'h2002, -2}; // evict idx3, rr=4
    vecs[22] = '{27'h7,   44'h0,    1'b0, 44'h1007, -2};
    vecs[23] = '{27'h3,   44'h2003, 1'b1, 44'h2003, -2}; // evict idx4, rr=5

    repeat (3) @(negedge clk);
    check("rst_ack", 64'(bus.ack), 64'd0);
    check("rst_ppn", 64'(bus.ppn), 64'd0);
    check("rst_req_valid", 64'(ptw_req_valid), 64'd0);
    check("rst_req_vpn", 64'(ptw_req_vpn), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Stray walker response while idle: no ack, no walk, cache contents intact.
    begin
      int stray_acks;
      stray_acks = 0;
      @(negedge clk);
      ptw_resp_valid = 1'b1;
      ptw_resp_ppn   = 44'hDEAD;
      @(negedge clk);
      ptw_resp_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
        if (bus.ack || ptw_req_valid) stray_acks++;
        @(negedge clk);
      end
      check("stray_resp_activity", 64'(stray_acks), 64'd0);
      v = '{27'h8, 44'h0, 1'b0, 44'h1008, -2};
      run_vec("stray_hit", v);
    end

    // Alternating hits from two arbiter sources: an ack every other cycle.
    begin
      logic [26:0] seq_vpn [4];
      logic [43:0] seq_ppn [4];
      int idx;
      int last;
      int extra;
      seq_vpn[0] = 27'h8; seq_ppn[0] = 44'h1008;
      seq_vpn[1] = 27'h7; seq_ppn[1] = 44'h1007;
      seq_vpn[2] = 27'h8; seq_ppn[2] = 44'h1008;
      seq_vpn[3] = 27'h7; seq_ppn[3] = 44'h1007;
      idx = 0;
      last = -10;
      extra = 0;
      @(negedge clk);
      bus.vpn   = seq_vpn[0];
      bus.valid = 1'b1;
      for (int cyc = 0; cyc < 30; cyc++) begin
        @(negedge clk);
        if (ptw_req_valid) extra++;
        if (bus.ack) begin
          if (idx >= 4) begin
            extra++;
          end else begin
            check($sformatf("b2b_ppn%0d", idx), 64'(bus.ppn), 64'(seq_ppn[idx]));
            if (idx > 0) check($sformatf("b2b_gap%0d", idx), 64'(cyc - last), 64'd2);
            last = cyc;
            idx++;
            if (idx < 4) bus.vpn = seq_vpn[idx];
            else bus.valid = 1'b0;
          end
        end
        if (idx >= 4 && cyc >= last + 3) break;
      end
      bus.valid = 1'b0;
      check("b2b_ack_count", 64'(idx), 64'd4);
      check("b2b_no_extra", 64'(extra), 64'd0);
    end

    // Reset while a walk is outstanding: outputs drop at once, cache is emptied.
    begin
      int seen;
      seen = 0;
      @(negedge clk);
      bus.vpn   = 27'h999;
      bus.valid = 1'b1;
      for (int c = 0; c < 10 && seen == 0; c++) begin
        @(negedge clk);
        if (ptw_req_valid) seen = 1;
      end
      check("midwalk_req_seen", 64'(seen), 64'd1);
      bus.valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midwalk_rst_req_valid", 64'(ptw_req_valid), 64'd0);
      check("midwalk_rst_req_vpn", 64'(ptw_req_vpn), 64'd0);
      check("midwalk_rst_ack", 64'(bus.ack), 64'd0);
      check("midwalk_rst_ppn", 64'(bus.ppn), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      v = '{27'h8, 44'h3008, 1'b1, 44'h3008, -2};
      run_vec("post_rst", v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
